ppu_regfile: RTL and testbench

Parametrised CPU-facing register file for the PPU: decodes the eight $2000–$2007 registers and drives the VRAM, palette and OAM ports. Adds over the previous generation:
- loopy v/t/x/w scroll-address registers;
- a PPUDATA read buffer;
- a synchronous vblank flag with suppression;
- an NMI output;
- parametrised address widths.

Sits between the CPU bus decoder and the PPU rendering/memory blocks.

---
 rtl/ppu_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_ppu_regfile.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_regfile.sv
// CPU-facing PPU register file ($2000-$2007): loopy scroll registers, vblank/NMI, VRAM/palette/OAM ports.
// Optional PPUDATA read buffer enabled by defining PPU_READ_BUFFER_EN.
module ppu_regfile #(
   parameter int unsigned VADDR_W = 14,
   parameter int unsigned OAM_AW  = 8,
   parameter int unsigned PAL_AW  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs_n,
   input  logic               we,
   input  logic [2:0]         reg_addr,
   input  logic [7:0]         cpu_din,
   output logic [7:0]         cpu_dout,
   output logic [VADDR_W-1:0] vram_addr,
   input  logic [7:0]         vram_rdata,
   output logic [7:0]         vram_wdata,
   output logic               vram_we,
   output logic [PAL_AW-1:0]  pal_addr,
   input  logic [7:0]         pal_rdata,
   output logic               pal_we,
   output logic [OAM_AW-1:0]  oam_addr,
   input  logic [7:0]         oam_rdata,
   output logic [7:0]         oam_wdata,
   output logic               oam_we,
   input  logic               vblank_set,
   input  logic               prerender_clr,
   input  logic               spr_ovf,
   input  logic               spr0_hit,
   output logic [7:0]         ppuctrl,
   output logic [7:0]         ppumask,
   output logic [14:0]        t_addr,
   output logic [2:0]         fine_x,
   output logic               nmi_n
);

   typedef enum logic [2:0] {
      REG_CTRL    = 3'd0,
      REG_MASK    = 3'd1,
      REG_STATUS  = 3'd2,
      REG_OAMADDR = 3'd3,
      REG_OAMDATA = 3'd4,
      REG_SCROLL  = 3'd5,
      REG_ADDR    = 3'd6,
      REG_DATA    = 3'd7
   } reg_e;

   reg_e               sel;
   logic               cs_n_q;
   logic               accept;
   logic               wr_acc;
   logic               rd_acc;
   logic               status_rd;
   logic               pal_space;
   logic [14:0]        v;
   logic [14:0]        t;
   logic [14:0]        v_inc;
   logic               w;
   logic [4:0]         open_bus;
   logic               vblank;
   logic [VADDR_W-1:0] wr_v;
   logic               strobe;
   logic [7:0]         data_rd;
   logic [7:0]         rd_data;

   assign sel       = reg_e'(reg_addr);
   assign accept    = ~cs_n & cs_n_q;
   assign wr_acc    = accept & we;
   assign rd_acc    = accept & ~we;
   assign status_rd = rd_acc & (sel == REG_STATUS);
   assign pal_space = (v[13:8] == 6'h3F);
   assign v_inc     = v + (ppuctrl[2] ? 15'd32 : 15'd1);
   assign t_addr    = t;

   // v has already advanced by the time a write strobe is visible, so the
   // strobe cycle presents the latched pre-increment address instead.
   assign strobe    = vram_we | pal_we;
   assign vram_addr = strobe ? wr_v : v[VADDR_W-1:0];
   assign pal_addr  = strobe ? wr_v[PAL_AW-1:0] : v[PAL_AW-1:0];

`ifdef PPU_READ_BUFFER_EN
   logic [7:0] rd_buf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_buf <= '0;
      end else if (rd_acc && sel == REG_DATA) begin
         rd_buf <= vram_rdata;
      end
   end

   assign data_rd = pal_space ? pal_rdata : rd_buf;
`else
   assign data_rd = pal_space ? pal_rdata : vram_rdata;
`endif

   always_comb begin
      rd_data = {3'b000, open_bus};
      case (sel)
         REG_STATUS:  rd_data = {vblank, spr0_hit, spr_ovf, open_bus};
         REG_OAMDATA: rd_data = oam_rdata;
         REG_DATA:    rd_data = data_rd;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_n_q     <= 1'b1;
         cpu_dout   <= '0;
         ppuctrl    <= '0;
         ppumask    <= '0;
         v          <= '0;
         t          <= '0;
         fine_x     <= '0;
         w          <= 1'b0;
         open_bus   <= '0;
         oam_addr   <= '0;
         oam_wdata  <= '0;
         vram_wdata <= '0;
         wr_v       <= '0;
         vram_we    <= 1'b0;
         pal_we     <= 1'b0;
         oam_we     <= 1'b0;
         vblank     <= 1'b0;
         nmi_n      <= 1'b1;
      end else begin
         cs_n_q  <= cs_n;
         vram_we <= 1'b0;
         pal_we  <= 1'b0;
         oam_we  <= 1'b0;
         nmi_n   <= ~(vblank & ppuctrl[7]);

         // OAM address advances once the write strobe has been presented.
         if (oam_we) begin
            oam_addr <= oam_addr + 1'b1;
         end

         // A status read in the set cycle suppresses the flag; clear beats set.
         if (prerender_clr || status_rd) begin
            vblank <= 1'b0;
         end else if (vblank_set) begin
            vblank <= 1'b1;
         end

         if (rd_acc) begin
            cpu_dout <= rd_data;
         end

         if (status_rd) begin
            w <= 1'b0;
         end

         if (wr_acc) begin
            open_bus <= cpu_din[4:0];
            case (sel)
               REG_CTRL: begin
                  ppuctrl  <= cpu_din;
                  t[11:10] <= cpu_din[1:0];
               end
               REG_MASK: ppumask <= cpu_din;
               REG_OAMADDR: oam_addr <= OAM_AW'(cpu_din);
               REG_OAMDATA: begin
                  oam_wdata <= cpu_din;
                  oam_we    <= 1'b1;
               end
               REG_SCROLL: begin
                  if (!w) begin
                     t[4:0] <= cpu_din[7:3];
                     fine_x <= cpu_din[2:0];
                  end else begin
                     t[14:12] <= cpu_din[2:0];
                     t[9:5]   <= cpu_din[7:3];
                  end
                  w <= ~w;
               end
               REG_ADDR: begin
                  if (!w) begin
                     t[13:8] <= cpu_din[5:0];
                     t[14]   <= 1'b0;
                  end else begin
                     t[7:0] <= cpu_din;
                     v      <= {t[14:8], cpu_din};
                  end
                  w <= ~w;
               end
               REG_DATA: begin
                  // Palette writes share vram_wdata as their data bus.
                  vram_wdata <= cpu_din;
                  wr_v       <= v[VADDR_W-1:0];
                  if (pal_space) begin
                     pal_we <= 1'b1;
                  end else begin
                     vram_we <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         if (accept && sel == REG_DATA) begin
            v <= v_inc;
         end
      end
   end

endmodule

// File: tb/tb_ppu_regfile.sv
// Directed bench for ppu_regfile: access-level model checked every cycle plus literal expectations.
module tb_ppu_regfile;

   logic        clk = 1'b0;
   logic        reset, cs_n, we, vblank_set, prerender_clr, spr_ovf, spr0_hit;
   logic [2:0]  reg_addr;
   logic [7:0]  cpu_din, cpu_dout, vram_rdata, vram_wdata, pal_rdata, oam_rdata, oam_wdata;
   logic [7:0]  ppuctrl, ppumask;
   logic [13:0] vram_addr;
   logic [4:0]  pal_addr;
   logic [7:0]  oam_addr;
   logic        vram_we, pal_we, oam_we, nmi_n;
   logic [14:0] t_addr;
   logic [2:0]  fine_x;

   always #5 clk = ~clk;

   ppu_regfile #(.VADDR_W(14), .OAM_AW(8), .PAL_AW(5)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .we(we), .reg_addr(reg_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr),
      .vram_rdata(vram_rdata), .vram_wdata(vram_wdata), .vram_we(vram_we),
      .pal_addr(pal_addr), .pal_rdata(pal_rdata), .pal_we(pal_we),
      .oam_addr(oam_addr), .oam_rdata(oam_rdata), .oam_wdata(oam_wdata),
      .oam_we(oam_we), .vblank_set(vblank_set), .prerender_clr(prerender_clr),
      .spr_ovf(spr_ovf), .spr0_hit(spr0_hit), .ppuctrl(ppuctrl),
      .ppumask(ppumask), .t_addr(t_addr), .fine_x(fine_x), .nmi_n(nmi_n)
   );

   // Memories attached to the DUT ports (one-cycle read latency).
   logic [7:0] vmem [0:16383];
   logic [7:0] pmem [0:31];
   logic [7:0] omem [0:255];

   always @(posedge clk) begin
      vram_rdata <= vmem[vram_addr];
      pal_rdata  <= pmem[pal_addr];
      oam_rdata  <= omem[oam_addr];
      if (vram_we) vmem[vram_addr] <= vram_wdata;
      if (pal_we)  pmem[pal_addr]  <= vram_wdata;
      if (oam_we)  omem[oam_addr]  <= oam_wdata;
   end

   // Access-level model: expected output values after the coming clock edge.
   logic [7:0]  mv [0:16383];
   logic [7:0]  mp [0:31];
   logic [7:0]  mo [0:255];
   logic [7:0]  m_ctrl, m_mask, m_dout, m_wd, m_owd, m_oaddr, m_rbuf;
   logic [14:0] m_v, m_t, m_sadr;
   logic [2:0]  m_fx;
   logic [4:0]  m_ob;
   logic        m_w, m_vbl, m_nmi, m_vwe, m_pwe, m_owe, m_prev_cs;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset;
      m_ctrl = 0; m_mask = 0; m_dout = 0; m_wd = 0; m_owd = 0; m_oaddr = 0; m_rbuf = 0;
      m_v = 0; m_t = 0; m_sadr = 0; m_fx = 0; m_ob = 0; m_w = 0; m_vbl = 0; m_nmi = 1;
      m_vwe = 0; m_pwe = 0; m_owe = 0; m_prev_cs = 1;
   endtask

   task automatic model_step;
      logic acc, pal, stat_rd, nmi_next;
      logic [14:0] inc;
      if (reset) begin
         model_reset();
         return;
      end
      nmi_next  = ~(m_vbl & m_ctrl[7]);
      acc       = !cs_n && m_prev_cs;
      m_prev_cs = cs_n;
      if (m_owe) m_oaddr = m_oaddr + 8'd1;
      m_vwe = 0; m_pwe = 0; m_owe = 0;
      pal     = (m_v[13:8] == 6'h3F);
      inc     = m_ctrl[2] ? 15'd32 : 15'd1;
      stat_rd = acc && !we && reg_addr == 3'd2;
      if (acc && !we) begin
         case (reg_addr)
            3'd2: begin m_dout = {m_vbl, spr0_hit, spr_ovf, m_ob}; m_w = 0; end
            3'd4: m_dout = mo[m_oaddr];
            3'd7: begin
`ifdef PPU_READ_BUFFER_EN
               m_dout = pal ? mp[m_v[4:0]] : m_rbuf;
               m_rbuf = mv[m_v[13:0]];
`else
               m_dout = pal ? mp[m_v[4:0]] : mv[m_v[13:0]];
`endif
               m_v = m_v + inc;
            end
            default: m_dout = {3'b000, m_ob};
         endcase
      end
      if (acc && we) begin
         m_ob = cpu_din[4:0];
         case (reg_addr)
            3'd0: begin m_ctrl = cpu_din; m_t[11:10] = cpu_din[1:0]; end
            3'd1: m_mask = cpu_din;
            3'd3: m_oaddr = cpu_din;
            3'd4: begin m_owd = cpu_din; m_owe = 1; mo[m_oaddr] = cpu_din; end
            3'd5: begin
               if (!m_w) begin m_t[4:0] = cpu_din[7:3]; m_fx = cpu_din[2:0]; end
               else begin m_t[14:12] = cpu_din[2:0]; m_t[9:5] = cpu_din[7:3]; end
               m_w = !m_w;
            end
            3'd6: begin
               if (!m_w) m_t[14:8] = {1'b0, cpu_din[5:0]};
               else begin m_t[7:0] = cpu_din; m_v = m_t; end
               m_w = !m_w;
            end
            3'd7: begin
               m_wd = cpu_din; m_sadr = m_v;
               if (pal) begin m_pwe = 1; mp[m_v[4:0]] = cpu_din; end
               else begin m_vwe = 1; mv[m_v[13:0]] = cpu_din; end
               m_v = m_v + inc;
            end
            default: ;
         endcase
      end
      if (prerender_clr || stat_rd) m_vbl = 0;
      else if (vblank_set) m_vbl = 1;
      m_nmi = nmi_next;
   endtask

   // Per-cycle compare against the model, 1 time unit after the edge.
   always @(posedge clk) begin
      logic [14:0] ea;
      #1;
      if (chk_en) begin
         ea = (m_vwe || m_pwe) ? m_sadr : m_v;
         chk("cpu_dout", {8'h0, cpu_dout}, {8'h0, m_dout});
         chk("ppuctrl", {8'h0, ppuctrl}, {8'h0, m_ctrl});
         chk("ppumask", {8'h0, ppumask}, {8'h0, m_mask});
         chk("vram_addr", {2'b0, vram_addr}, {2'b0, ea[13:0]});
         chk("pal_addr", {11'h0, pal_addr}, {11'h0, ea[4:0]});
         chk("vram_wdata", {8'h0, vram_wdata}, {8'h0, m_wd});
         chk("vram_we", {15'h0, vram_we}, {15'h0, m_vwe});
         chk("pal_we", {15'h0, pal_we}, {15'h0, m_pwe});
         chk("oam_addr", {8'h0, oam_addr}, {8'h0, m_oaddr});
         chk("oam_wdata", {8'h0, oam_wdata}, {8'h0, m_owd});
         chk("oam_we", {15'h0, oam_we}, {15'h0, m_owe});
         chk("t_addr", {1'b0, t_addr}, {1'b0, m_t});
         chk("fine_x", {13'h0, fine_x}, {13'h0, m_fx});
         chk("nmi_n", {15'h0, nmi_n}, {15'h0, m_nmi});
      end
   end

   task automatic cyc(input logic rst, input logic cs, input logic w_, input logic [2:0] a,
                      input logic [7:0] d, input logic vs, input logic pc);
      @(negedge clk);
      reset = rst; cs_n = cs; we = w_; reg_addr = a; cpu_din = d;
      vblank_set = vs; prerender_clr = pc;
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle;
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pulse(input logic vs, input logic pc);
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, vs, pc);
   endtask

   task automatic acc_vs(input logic w_, input logic [2:0] a, input logic [7:0] d, input logic vs);
      idle();
      idle();
      cyc(1'b0, 1'b0, w_, a, d, vs, 1'b0);
   endtask

   task automatic acc(input logic w_, input logic [2:0] a, input logic [7:0] d);
      acc_vs(w_, a, d, 1'b0);
   endtask

   initial begin
      reset = 1'b1; cs_n = 1'b1; we = 1'b0; reg_addr = 3'd0; cpu_din = 8'h00;
      vblank_set = 1'b0; prerender_clr = 1'b0; spr_ovf = 1'b0; spr0_hit = 1'b1;
      for (int i = 0; i < 16384; i++) begin vmem[i] = 8'h00; mv[i] = 8'h00; end
      for (int i = 0; i < 32; i++) begin pmem[i] = 8'h00; mp[i] = 8'h00; end
      for (int i = 0; i < 256; i++) begin omem[i] = 8'h00; mo[i] = 8'h00; end
      vmem[14'h0200] = 8'h11; mv[14'h0200] = 8'h11;
      vmem[14'h0201] = 8'h22; mv[14'h0201] = 8'h22;
      model_reset();
      chk_en = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      chk("rst_nmi", {15'h0, nmi_n}, 16'h1);
      chk("rst_dout", {8'h0, cpu_dout}, 16'h0);
      idle();

      // PPUADDR $21,$08 then PPUDATA $5A
      acc(1'b1, 3'd6, 8'h21);
      acc(1'b1, 3'd6, 8'h08);
      acc(1'b1, 3'd7, 8'h5A);
      chk("wr_strobe", {15'h0, vram_we}, 16'h1);
      chk("wr_addr", {2'b0, vram_addr}, 16'h2108);
      chk("wr_data", {8'h0, vram_wdata}, 16'h005A);
      idle();
      chk("wr_strobe_end", {15'h0, vram_we}, 16'h0);
      chk("v_inc1", {2'b0, vram_addr}, 16'h2109);

      // increment by 32
      acc(1'b1, 3'd0, 8'h04);
      acc(1'b1, 3'd6, 8'h21);
      acc(1'b1, 3'd6, 8'h08);
      acc(1'b1, 3'd7, 8'h77);
      idle();
      chk("v_inc32", {2'b0, vram_addr}, 16'h2128);

      // PPUDATA reads at $0200
      acc(1'b1, 3'd0, 8'h00);
      acc(1'b1, 3'd6, 8'h02);
      acc(1'b1, 3'd6, 8'h00);
      acc(1'b0, 3'd7, 8'h00);
`ifdef PPU_READ_BUFFER_EN
      chk("rd1", {8'h0, cpu_dout}, 16'h0000);
      acc(1'b0, 3'd7, 8'h00);
      chk("rd2", {8'h0, cpu_dout}, 16'h0011);
      acc(1'b0, 3'd7, 8'h00);
      chk("rd3", {8'h0, cpu_dout}, 16'h0022);
`else
      chk("rd1", {8'h0, cpu_dout}, 16'h0011);
      acc(1'b0, 3'd7, 8'h00);
      chk("rd2", {8'h0, cpu_dout}, 16'h0022);
      acc(1'b0, 3'd7, 8'h00);
`endif
      idle();
      chk("rd_v", {2'b0, vram_addr}, 16'h0203);

      // vblank + NMI, status read
      acc(1'b1, 3'd0, 8'h80);
      pulse(1'b1, 1'b0);
      chk("nmi_lag", {15'h0, nmi_n}, 16'h1);
      idle();
      chk("nmi_fall", {15'h0, nmi_n}, 16'h0);
      acc(1'b0, 3'd2, 8'h00);
      chk("status", {8'h0, cpu_dout}, 16'h00C0);
      idle();
      chk("nmi_rise", {15'h0, nmi_n}, 16'h1);

      // suppression: status read coincides with vblank_set
      spr_ovf = 1'b1;
      acc_vs(1'b0, 3'd2, 8'h00, 1'b1);
      chk("suppress", {8'h0, cpu_dout}, 16'h0060);
      idle(); idle(); idle();
      chk("suppress_nmi", {15'h0, nmi_n}, 16'h1);
      spr_ovf = 1'b0;

      // PPUCTRL[7] set while vblank high; then clear beats set
      acc(1'b1, 3'd0, 8'h00);
      pulse(1'b1, 1'b0);
      idle(); idle();
      acc(1'b1, 3'd0, 8'h80);
      idle();
      chk("nmi_ctrl", {15'h0, nmi_n}, 16'h0);
      pulse(1'b1, 1'b1);
      idle();
      chk("clr_wins", {15'h0, nmi_n}, 16'h1);

      // PPUSCROLL
      acc(1'b1, 3'd5, 8'h7D);
      acc(1'b1, 3'd5, 8'h5E);
      chk("fine_x", {13'h0, fine_x}, 16'h5);
      chk("t_scroll", {1'b0, t_addr}, 16'h616F);

      // OAM wrap and readback
      acc(1'b1, 3'd3, 8'hFF);
      acc(1'b1, 3'd4, 8'hAA);
      chk("oam_we", {15'h0, oam_we}, 16'h1);
      chk("oam_at", {8'h0, oam_addr}, 16'h00FF);
      chk("oam_wd", {8'h0, oam_wdata}, 16'h00AA);
      idle();
      chk("oam_wrap", {8'h0, oam_addr}, 16'h0000);
      acc(1'b1, 3'd3, 8'hFF);
      acc(1'b0, 3'd4, 8'h00);
      chk("oam_rd", {8'h0, cpu_dout}, 16'h00AA);

      // palette write and read
      acc(1'b1, 3'd6, 8'h3F);
      acc(1'b1, 3'd6, 8'h01);
      acc(1'b1, 3'd7, 8'h2C);
      chk("pal_we", {15'h0, pal_we}, 16'h1);
      chk("pal_novram", {15'h0, vram_we}, 16'h0);
      chk("pal_addr", {11'h0, pal_addr}, 16'h0001);
      acc(1'b1, 3'd6, 8'h3F);
      acc(1'b1, 3'd6, 8'h01);
      acc(1'b0, 3'd7, 8'h00);
      chk("pal_rd", {8'h0, cpu_dout}, 16'h002C);

      // reserved reads return open bus
      acc(1'b1, 3'd1, 8'h1F);
      acc(1'b0, 3'd5, 8'h00);
      chk("open_bus1", {8'h0, cpu_dout}, 16'h001F);
      acc(1'b1, 3'd1, 8'hE3);
      acc(1'b0, 3'd0, 8'h00);
      chk("open_bus2", {8'h0, cpu_dout}, 16'h0003);
      chk("mask", {8'h0, ppumask}, 16'h00E3);

      // reset during a pending write strobe
      acc(1'b1, 3'd6, 8'h01);
      acc(1'b1, 3'd6, 8'h00);
      acc(1'b1, 3'd7, 8'h99);
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      chk("rst_we", {15'h0, vram_we}, 16'h0);
      chk("rst_ctrl", {8'h0, ppuctrl}, 16'h0);
      chk("rst_vaddr", {2'b0, vram_addr}, 16'h0);
      chk("rst_nmi2", {15'h0, nmi_n}, 16'h1);
      idle();
      acc(1'b0, 3'd2, 8'h00);
      chk("post_rst_status", {8'h0, cpu_dout}, 16'h0040);
      idle(); idle();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
